// File: rtl/max_net.sv
// Four-input winner-take-all (MaxNet) maximum finder: mutual lateral inhibition
// on fixed-point activations until a single neuron survives.
module max_net #(
   parameter int unsigned FRAC      = 6,
   parameter int unsigned EPS_SHIFT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] X1,
   input  logic [4:0] X2,
   input  logic [4:0] X3,
   input  logic [4:0] X4,
   output logic [4:0] max,
   output logic       done
);

   localparam int unsigned IN_W = 5;
   localparam int unsigned A_W  = IN_W + FRAC;
   localparam int unsigned S_W  = A_W + 2;
   localparam int unsigned N    = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [IN_W-1:0] in_q [N];
   logic [IN_W-1:0] in_d [N];
   logic [A_W-1:0]  a_q [N];
   logic [A_W-1:0]  a_d [N];
   logic [N-1:0]    prev_q, prev_d;
   logic [IN_W-1:0] max_q, max_d;
   logic            done_q, done_d;

   logic [N-1:0]    mask_c;
   logic [2:0]      cnt_c;
   logic [S_W-1:0]  total_c;
   logic [S_W-1:0]  s_c [N];
   logic [S_W-1:0]  sh_c [N];
   logic [S_W-1:0]  inh_c [N];
   logic [A_W-1:0]  upd_c [N];

   function automatic logic [1:0] lowest(input logic [N-1:0] m);
      lowest = 2'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (m[i]) lowest = 2'(i);
      end
   endfunction

   // Inhibition datapath: each neuron is pushed down by eps times the sum of the others
   always_comb begin
      total_c = '0;
      cnt_c   = '0;
      for (int i = 0; i < N; i++) begin
         mask_c[i] = (a_q[i] != '0);
         cnt_c     = cnt_c + 3'(mask_c[i]);
         total_c   = total_c + S_W'(a_q[i]);
      end
      for (int i = 0; i < N; i++) begin
         s_c[i]   = total_c - S_W'(a_q[i]);
         sh_c[i]  = s_c[i] >> EPS_SHIFT;
         // Minimum inhibition of one LSB guarantees progress on small activations
         inh_c[i] = ((s_c[i] != '0) && (sh_c[i] == '0)) ? S_W'(1) : sh_c[i];
         upd_c[i] = (inh_c[i] >= S_W'(a_q[i])) ? '0 : A_W'(S_W'(a_q[i]) - inh_c[i]);
      end
   end

   // Control FSM and next-state for all registers
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      max_d   = max_q;
      done_d  = done_q;
      for (int i = 0; i < N; i++) begin
         in_d[i] = in_q[i];
         a_d[i]  = a_q[i];
      end
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            in_d[0] = X1;
            in_d[1] = X2;
            in_d[2] = X3;
            in_d[3] = X4;
            a_d[0]  = {X1, {FRAC{1'b0}}};
            a_d[1]  = {X2, {FRAC{1'b0}}};
            a_d[2]  = {X3, {FRAC{1'b0}}};
            a_d[3]  = {X4, {FRAC{1'b0}}};
            prev_d  = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (cnt_c == 3'd1) begin
               max_d   = in_q[lowest(mask_c)];
               done_d  = 1'b1;
               state_d = S_FIN;
            end else if (cnt_c == 3'd0) begin
               // Tied maxima died together; the lowest survivor of the previous step wins
               max_d   = (prev_q != '0) ? in_q[lowest(prev_q)] : '0;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               for (int i = 0; i < N; i++) a_d[i] = upd_c[i];
               prev_d = mask_c;
            end
         end
         S_FIN: begin
            if (start) begin
               done_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         prev_q  <= '0;
         max_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            in_q[i] <= '0;
            a_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         max_q   <= max_d;
         done_q  <= done_d;
         for (int i = 0; i < N; i++) begin
            in_q[i] <= in_d[i];
            a_q[i]  <= a_d[i];
         end
      end
   end

   assign max  = max_q;
   assign done = done_q;

endmodule

// File: tb/tb_max_net.sv
// Self-checking bench for max_net: directed scenarios plus randomized inputs
// compared against an integer-arithmetic MaxNet reference.
module tb_max_net;

   localparam int LIMIT = 3000;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] X1, X2, X3, X4;
   logic [4:0] max_o;
   logic       done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   max_net dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .X1    (X1),
      .X2    (X2),
      .X3    (X3),
      .X4    (X4),
      .max   (max_o),
      .done  (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: winner value and number of iteration cycles, using plain integers
   function automatic void ref_run(input int x[4], output int win, output int iters);
      int a[4];
      int na[4];
      int tot, act, first, prev_low, s, inh;
      for (int i = 0; i < 4; i++) a[i] = x[i] * 64;
      prev_low = -1;
      iters    = 0;
      win      = 0;
      for (int it = 0; it < 4096; it++) begin
         iters++;
         act   = 0;
         tot   = 0;
         first = -1;
         for (int i = 0; i < 4; i++) begin
            if (a[i] > 0) begin
               act++;
               if (first < 0) first = i;
            end
            tot += a[i];
         end
         if (act == 1) begin
            win = x[first];
            return;
         end
         if (act == 0) begin
            win = (prev_low >= 0) ? x[prev_low] : 0;
            return;
         end
         for (int i = 0; i < 4; i++) begin
            s   = tot - a[i];
            inh = s / 8;
            if (s > 0 && inh == 0) inh = 1;
            na[i] = (a[i] > inh) ? a[i] - inh : 0;
         end
         a        = na;
         prev_low = first;
      end
   endfunction

   task automatic run_op(input int x0, input int x1, input int x2, input int x3);
      int xv[4];
      int win, iters, n, mx;
      logic [4:0] held;
      xv = '{x0, x1, x2, x3};
      ref_run(xv, win, iters);
      mx = 0;
      for (int i = 0; i < 4; i++) if (xv[i] > mx) mx = xv[i];
      X1 = 5'(x0);
      X2 = 5'(x1);
      X3 = 5'(x2);
      X4 = 5'(x3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("done_low_after_start", 32'(done), 32'd0);
      @(posedge clk); #1;
      // Inputs are already captured; scramble them to prove independence
      X1 = 5'($urandom);
      X2 = 5'($urandom);
      X3 = 5'($urandom);
      X4 = 5'($urandom);
      n = 1;
      while (done !== 1'b1 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("done_rise", 32'(done), 32'd1);
      check_eq("latency", 32'(n), 32'(1 + iters));
      check_eq("max_vs_model", 32'(max_o), 32'(win));
      check_eq("max_vs_inputs", 32'(max_o), 32'(mx));
      held = max_o;
      repeat (2) @(posedge clk);
      #1;
      check_eq("done_held", 32'(done), 32'd1);
      check_eq("max_held", 32'(max_o), 32'(held));
   endtask

   initial begin
      int v[4];
      rst   = 1'b1;
      start = 1'b0;
      X1 = '0; X2 = '0; X3 = '0; X4 = '0;
      #10;
      check_eq("reset_max", 32'(max_o), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      #5 rst = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_done", 32'(done), 32'd0);

      run_op(8, 6, 4, 2);
      run_op(5, 5, 3, 1);
      run_op(0, 0, 17, 0);
      run_op(0, 0, 0, 0);
      run_op(31, 30, 0, 29);
      run_op(1, 2, 3, 4);
      run_op(31, 31, 31, 31);
      run_op(0, 9, 0, 9);

      // Reset while iterating
      X1 = 5'd31; X2 = 5'd30; X3 = 5'd0; X4 = 5'd29;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("midrun_reset_max", 32'(max_o), 32'd0);
      check_eq("midrun_reset_done", 32'(done), 32'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_reset_done", 32'(done), 32'd0);
      run_op(12, 3, 27, 26);

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) v[$urandom_range(0, 3)] = v[$urandom_range(0, 3)];
         if ($urandom_range(0, 4) == 0) v[$urandom_range(0, 3)] = 0;
         run_op(v[0], v[1], v[2], v[3]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
